// File: rtl/delay_line_sink.sv
// delay_line_sink
//   Credit-managed receive buffer at the far end of a fixed-latency,
//   enable-gated delay line. Upstream may launch an item only while a credit
//   is available; every stored item or in-flight item holds one credit until
//   the consumer pops it. The buffer is a first-word fall-through FIFO.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   issue      upstream launches an item into the delay line this cycle
//   issue_ok   a credit is available (credits != 0)
//   in_valid   an item emerges from the delay line this cycle
//   in_data    payload of the emerging item
//   out_valid  out_data holds a valid item (count != 0)
//   out_data   head-of-buffer item
//   out_ready  consumer accepts the head item
//   count      items currently stored
//   overflow   sticky: an item arrived with no free entry and was discarded
module delay_line_sink #(
    parameter int DATA_WIDTH   = 128,
    parameter int CLOCK_CYCLES = 8,
    parameter int DEPTH        = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue,
    output logic                         issue_ok,
    input  logic                         in_valid,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Parameter sanity: pointer wrap relies on DEPTH being a power of two.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CLOCK_CYCLES < 0) begin : g_param_check
        $error("delay_line_sink: DEPTH must be a power of two >= 2");
    end

    logic [CW-1:0]         credits;
    logic [CW-1:0]         count_q;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  overflow_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic pop;
    logic push;
    logic take;
    logic full;

    always_comb begin
        full = (count_q == FULL);
        pop  = (count_q != '0) && out_ready;
        // A full buffer still accepts an arrival when the head leaves in the
        // same cycle: the read sees the old entry, the write lands behind it.
        push = in_valid && (!full || pop);
        take = issue && (credits != '0);
    end

    assign issue_ok  = (credits != '0);
    assign out_valid = (count_q != '0);
    assign out_data  = mem[rd_ptr];
    assign count     = count_q;
    assign overflow  = overflow_q;

    // Credits: a launch consumes one, a pop returns one, both together cancel.
    // Saturation only matters if items are injected without a launch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits <= FULL;
        end else begin
            case ({take, pop})
                2'b10:   credits <= credits - CW'(1);
                2'b01:   if (credits != FULL) credits <= credits + CW'(1);
                default: credits <= credits;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (in_valid && !push) begin
            overflow_q <= 1'b1;
        end
    end

    // Storage is not reset; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_delay_line_sink.sv
module tb_delay_line_sink;

    localparam int W     = 32;
    localparam int DEPTH = 8;
    localparam int TB_CC = 6;

    logic          clk;
    logic          rst;
    logic          issue;
    logic          issue_ok;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic [3:0]    count;
    logic          overflow;

    delay_line_sink #(
        .DATA_WIDTH   (W),
        .CLOCK_CYCLES (TB_CC),
        .DEPTH        (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .issue     (issue),
        .issue_ok  (issue_ok),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    // Reference model: item queue, credit integer, sticky overflow bit.
    logic [W-1:0] m_q[$];
    int           m_credits;
    logic         m_ovf;

    // Upstream delay line model.
    logic         pipe_v [TB_CC];
    logic [W-1:0] pipe_d [TB_CC];

    // Observed pops from the DUT.
    logic [W-1:0] d_out[$];
    int           d_cyc[$];

    logic         bp_mode;
    logic         prev_stall;
    logic [W-1:0] prev_data;

    typedef struct {
        logic         iss;
        logic         iv;
        logic [W-1:0] d;
        logic         rdy;
        int           exp_count;
        logic         exp_valid;
        logic         exp_ok;
        logic [W-1:0] exp_data;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_credits  = DEPTH;
        m_ovf      = 1'b0;
        prev_stall = 1'b0;
        for (int i = 0; i < TB_CC; i++) begin
            pipe_v[i] = 1'b0;
            pipe_d[i] = '0;
        end
    endtask

    task automatic model_check();
        chk("issue_ok", 64'(issue_ok), 64'(m_credits != 0));
        chk("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
        chk("count", 64'(count), 64'(m_q.size()));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        if (m_q.size() != 0) chk("out_data", 64'(out_data), 64'(m_q[0]));
        if (bp_mode && prev_stall) chk("stall_hold", 64'(out_data), 64'(prev_data));
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        if (out_valid && out_ready) begin
            d_out.push_back(out_data);
            d_cyc.push_back(cyc);
        end
    endtask

    task automatic model_update(input logic iss, input logic iv, input logic [W-1:0] id,
                                input logic rdy);
        logic p_pop;
        logic p_push;
        logic p_acc;
        p_pop  = (m_q.size() != 0) && rdy;
        p_push = iv && ((m_q.size() < DEPTH) || p_pop);
        p_acc  = iss && (m_credits != 0);
        if (p_pop) void'(m_q.pop_front());
        if (p_push) m_q.push_back(id);
        if (iv && !p_push) m_ovf = 1'b1;
        m_credits = m_credits - (p_acc ? 1 : 0) + (p_pop ? 1 : 0);
        if (m_credits > DEPTH) m_credits = DEPTH;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input logic iss, input logic iv, input logic [W-1:0] id,
                         input logic rdy);
        issue     = iss;
        in_valid  = iv;
        in_data   = id;
        out_ready = rdy;
        #1;
        model_check();
        @(posedge clk);
        model_update(iss, iv, id, rdy);
        cyc++;
        @(negedge clk);
    endtask

    task automatic dl_cycle(input logic iss, input logic [W-1:0] idata, input logic rdy,
                            input logic fv, input logic [W-1:0] fd);
        logic         iv;
        logic [W-1:0] id;
        logic         acc;
        iv  = pipe_v[TB_CC-1] | fv;
        id  = fv ? fd : pipe_d[TB_CC-1];
        acc = iss && (m_credits != 0);
        cycle(iss, iv, id, rdy);
        for (int i = TB_CC - 1; i > 0; i--) begin
            pipe_v[i] = pipe_v[i-1];
            pipe_d[i] = pipe_d[i-1];
        end
        pipe_v[0] = acc;
        pipe_d[0] = idata;
    endtask

    // Asynchronous reset pulse mid-cycle with busy inputs held during reset.
    task automatic do_reset();
        #2;
        rst       = 1'b1;
        issue     = 1'b1;
        in_valid  = 1'b1;
        in_data   = '1;
        out_ready = 1'b1;
        #1;
        chk("rst_async_count", 64'(count), 64'd0);
        chk("rst_async_valid", 64'(out_valid), 64'd0);
        chk("rst_async_ok", 64'(issue_ok), 64'd1);
        chk("rst_async_ovf", 64'(overflow), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_count", 64'(count), 64'd0);
        chk("rst_hold_valid", 64'(out_valid), 64'd0);
        chk("rst_hold_ok", 64'(issue_ok), 64'd1);
        @(negedge clk);
        rst       = 1'b0;
        issue     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        model_reset();
    endtask

    task automatic idle_until_size(input int n, input string name);
        for (int k = 0; k < 30 && m_q.size() != n; k++) dl_cycle(1'b0, '0, 1'b0, 1'b0, '0);
        chk(name, 64'(m_q.size()), 64'(n));
    endtask

    initial begin
        int n;
        logic acc;

        rst = 1'b1; issue = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        bp_mode = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("init_count", 64'(count), 64'd0);
        chk("init_valid", 64'(out_valid), 64'd0);
        chk("init_ok", 64'(issue_ok), 64'd1);
        chk("init_ovf", 64'(overflow), 64'd0);
        @(negedge clk);

        // Directly driven vectors; expectations are the state after the edge.
        tbl[0] = '{1'b1, 1'b1, 32'hA1, 1'b0, 1, 1'b1, 1'b1, 32'hA1};
        tbl[1] = '{1'b1, 1'b1, 32'hB2, 1'b0, 2, 1'b1, 1'b1, 32'hA1};
        tbl[2] = '{1'b0, 1'b0, 32'h00, 1'b1, 1, 1'b1, 1'b1, 32'hB2};
        tbl[3] = '{1'b0, 1'b1, 32'hC3, 1'b1, 1, 1'b1, 1'b1, 32'hC3};
        tbl[4] = '{1'b0, 1'b0, 32'h00, 1'b1, 0, 1'b0, 1'b1, 32'h00};
        tbl[5] = '{1'b0, 1'b0, 32'h00, 1'b1, 0, 1'b0, 1'b1, 32'h00};
        tbl[6] = '{1'b1, 1'b1, 32'hD4, 1'b1, 1, 1'b1, 1'b1, 32'hD4};
        for (int i = 0; i < 7; i++) begin
            cycle(tbl[i].iss, tbl[i].iv, tbl[i].d, tbl[i].rdy);
            #1;
            chk("tbl_count", 64'(count), 64'(tbl[i].exp_count));
            chk("tbl_valid", 64'(out_valid), 64'(tbl[i].exp_valid));
            chk("tbl_ok", 64'(issue_ok), 64'(tbl[i].exp_ok));
            if (tbl[i].exp_valid) chk("tbl_data", 64'(out_data), 64'(tbl[i].exp_data));
        end

        // Credit exhaustion.
        do_reset();
        for (int i = 0; i < DEPTH; i++) dl_cycle(1'b1, W'(32'h100 + i), 1'b0, 1'b0, '0);
        #1;
        chk("exhaust_ok", 64'(issue_ok), 64'd0);
        dl_cycle(1'b1, 32'hBAD, 1'b0, 1'b0, '0);
        idle_until_size(DEPTH, "exhaust_fill");
        for (int k = 0; k < TB_CC; k++) dl_cycle(1'b0, '0, 1'b0, 1'b0, '0);
        #1;
        chk("exhaust_count", 64'(count), 64'd8);
        chk("exhaust_ovf", 64'(overflow), 64'd0);
        chk("exhaust_head", 64'(out_data), 64'h100);

        // Credit return.
        dl_cycle(1'b0, '0, 1'b1, 1'b0, '0);
        #1;
        chk("return_pop", 64'(d_out[d_out.size()-1]), 64'h100);
        chk("return_count", 64'(count), 64'd7);
        chk("return_ok", 64'(issue_ok), 64'd1);

        // Overflow without pop: arrival dropped, contents intact.
        dl_cycle(1'b1, 32'h108, 1'b0, 1'b0, '0);
        idle_until_size(DEPTH, "ovf_fill");
        dl_cycle(1'b0, '0, 1'b0, 1'b1, 32'hDEAD);
        #1;
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_count", 64'(count), 64'd8);
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            chk("ovf_drain", 64'(out_data), 64'(32'h101 + i));
            dl_cycle(1'b0, '0, 1'b1, 1'b0, '0);
        end
        #1;
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // Full with simultaneous pop: arrival accepted, no overflow.
        do_reset();
        for (int i = 0; i < DEPTH; i++) dl_cycle(1'b1, W'(32'h200 + i), 1'b0, 1'b0, '0);
        idle_until_size(DEPTH, "fullpop_fill");
        dl_cycle(1'b0, '0, 1'b1, 1'b1, 32'hBEEF);
        #1;
        chk("fullpop_ovf", 64'(overflow), 64'd0);
        chk("fullpop_count", 64'(count), 64'd8);
        chk("fullpop_head", 64'(out_data), 64'h201);

        // Streaming at one item per cycle.
        do_reset();
        d_out.delete();
        d_cyc.delete();
        for (int i = 0; i < 100; i++) begin
            dl_cycle(1'b1, W'(32'h1000 + i), 1'b1, 1'b0, '0);
            #1;
            chk("stream_count_le1", 64'(count <= 4'd1), 64'd1);
            chk("stream_ok", 64'(issue_ok), 64'd1);
        end
        for (int k = 0; k < TB_CC + 3; k++) dl_cycle(1'b0, '0, 1'b1, 1'b0, '0);
        chk("stream_len", 64'(d_out.size()), 64'd100);
        if (d_out.size() == 100) begin
            chk("stream_nogap", 64'(d_cyc[99] - d_cyc[0]), 64'd99);
            for (int i = 0; i < 100; i++) chk("stream_order", 64'(d_out[i]), 64'(32'h1000 + i));
        end

        // Backpressure with out_ready toggling.
        do_reset();
        d_out.delete();
        d_cyc.delete();
        bp_mode = 1'b1;
        n = 1;
        for (int k = 0; k < 400 && d_out.size() < 32; k++) begin
            acc = (n <= 32) && (m_credits != 0);
            dl_cycle(n <= 32, W'(n), (k % 2) == 1, 1'b0, '0);
            if (acc) n++;
        end
        bp_mode = 1'b0;
        chk("bp_len", 64'(d_out.size()), 64'd32);
        for (int i = 0; i < 32 && i < d_out.size(); i++) chk("bp_order", 64'(d_out[i]), 64'(i + 1));

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            logic fv;
            fv = !pipe_v[TB_CC-1] && ($urandom_range(0, 15) == 0);
            dl_cycle($urandom_range(0, 1) == 1, W'($urandom), $urandom_range(0, 3) != 0,
                     fv, W'($urandom));
        end

        // Mid-operation reset with count=5, credits=1.
        do_reset();
        for (int i = 0; i < DEPTH - 1; i++) dl_cycle(1'b1, W'(32'h300 + i), 1'b0, 1'b0, '0);
        idle_until_size(5, "midrst_fill");
        chk("midrst_count", 64'(count), 64'd5);
        chk("midrst_credit", 64'(m_credits), 64'd1);
        do_reset();
        for (int k = 0; k < 4; k++) dl_cycle(1'b0, '0, 1'b1, 1'b0, '0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/delay_line_sink.md
DELAY_LINE_SINK -- requirements
Module: delay_line_sink

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, width of each data item.
REQ-002 SHALL have parameter CLOCK_CYCLES, default 8, fixed latency of the upstream enable-gated delay line feeding this block.
REQ-003 SHALL have parameter DEPTH, default 8, number of storage entries; power of two and at least 2.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port issue  input  1  upstream launches one item into the delay line this cycle.
REQ-007 SHALL have port issue_ok  output  1  upstream may launch an item (a credit is available).
REQ-008 SHALL have port in_valid  input  1  item emerging from the delay line this cycle.
REQ-009 SHALL have port in_data  input  DATA_WIDTH  emerging item payload.
REQ-010 SHALL have port out_valid  output  1  out_data holds a valid item.
REQ-011 SHALL have port out_data  output  DATA_WIDTH  head-of-buffer item.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the head item.
REQ-013 SHALL have port count  output  clog2(DEPTH+1)  items currently stored.
REQ-014 SHALL have port overflow  output  1  sticky error: item arrived with no free entry.

Function
REQ-015 SHALL hold a credit counter, range 0..DEPTH, counting entries neither stored nor reserved by an in-flight item.
REQ-016 SHALL drive issue_ok = (credits != 0), combinationally from the registered counter.
REQ-017 SHALL decrement credits on issue && issue_ok; issue while issue_ok=0 SHALL be ignored.
REQ-018 SHALL increment credits on pop (out_valid && out_ready).
REQ-019 SHALL leave credits unchanged when an accepted issue and a pop occur in the same cycle.
REQ-020 SHALL write in_data into the entry at wr_ptr on push (in_valid with a free entry), then advance wr_ptr modulo DEPTH.
REQ-021 SHALL present the entry at rd_ptr on out_data (first-word fall-through) with out_valid = (count != 0).
REQ-022 SHALL advance rd_ptr modulo DEPTH on pop.
REQ-023 SHALL update count by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-024 SHALL treat a push when count==DEPTH and a pop in the same cycle as legal: the write and the read both complete.
REQ-025 SHALL set overflow, and SHALL discard in_data, when in_valid arrives with count==DEPTH and no pop; overflow SHALL hold until reset.
REQ-026 SHALL leave out_data and the storage unchanged while out_valid=1 and out_ready=0.
REQ-027 SHALL never modify pointers, count or credits on out_ready while out_valid=0.
REQ-028 SHALL wrap both pointers from DEPTH-1 to 0 with no bubble cycle.
REQ-029 SHALL sustain one push and one pop per cycle indefinitely when credits are returned, for a throughput of 1 item/cycle.
REQ-030 SHALL have zero added latency: an item pushed at edge N is visible on out_data after edge N.

Reset
REQ-031 SHALL, on rst assertion at any time including mid-transfer, immediately force credits=DEPTH, count=0, wr_ptr=0, rd_ptr=0 and overflow=0.
REQ-032 SHALL during and after reset drive issue_ok=1, out_valid=0 and count=0; out_data is don't-care and the storage is not cleared.
REQ-033 SHALL ignore all inputs while rst=1 and resume on the first rising edge after deassertion.

Verification
REQ-034 SHALL cover credit exhaustion: DEPTH=8, 8 issues, out_ready=0, 8 arrivals after CLOCK_CYCLES -> issue_ok=0 after 8th issue, count=8, overflow=0.
REQ-035 SHALL cover credit return: from the full state, one pop -> the popped item is the first one stored, count=7, issue_ok=1 next cycle.
REQ-036 SHALL cover streaming: issue every cycle with out_ready=1 for 100 cycles -> 100 items out in order with no gaps, count<=1, issue_ok stays 1.
REQ-037 SHALL cover overflow: count=8, forced in_valid=1 with out_ready=0 -> overflow=1, count=8, stored data intact; a simultaneous pop instead -> overflow=0.
REQ-038 SHALL cover backpressure: out_ready toggling 0/1 with data 0x1..0x20 -> output sequence exactly 0x1..0x20, out_data stable while stalled.
REQ-039 SHALL cover mid-operation reset: rst pulsed with count=5 and credits=1 -> count=0, out_valid=0, issue_ok=1, overflow=0 without waiting for a clock edge.
